// File: rtl/pwm_duty_decoder.sv
// PWM duty-cycle decoder: measures high time and period of pwm_in and
// divides them into a W-bit duty code.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-high
//   pwm_in        asynchronous PWM input
//   duty          last decoded duty code
//   duty_valid    one-cycle pulse when duty/period/high_time update
//   period        last measured period in clk cycles
//   high_time     last measured high time in clk cycles
//   static_level  1 = last update came from a timeout, not from edges
//   overrun       sticky, set when a capture is dropped while dividing
module pwm_duty_decoder #(
    parameter int W       = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [W-1:0]     duty,
    output logic             duty_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             static_level,
    output logic             overrun
);

    localparam int DW   = CNT_W + W;
    localparam int IT_W = $clog2(W + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
    localparam logic [IT_W-1:0]  IT_LAST = IT_W'(W);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic sync1;
    logic pwm_s;
    logic pwm_d;
    logic rise;

    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic             armed;
    logic             tmo_hit;
    logic             tmo_pend;
    logic             tmo_lvl;
    logic             tmo_val;

    logic cap;
    logic drop;
    logic last_it;

    logic div_load;
    logic div_fin;
    logic div_step;
    logic tmo_apply;

    logic [DW-1:0]    rem_q;
    logic [DW-1:0]    dsh_q;
    logic [DW-1:0]    rem_nx;
    logic             ge;
    logic [W:0]       q_q;
    logic [W:0]       q_nx;
    logic [W-1:0]     q_sat;
    logic [IT_W-1:0]  it_q;
    logic [CNT_W-1:0] p_q;
    logic [CNT_W-1:0] h_q;

    // Input synchronizer plus one extra stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            pwm_s <= 1'b0;
            pwm_d <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            pwm_s <= sync1;
            pwm_d <= pwm_s;
        end
    end

    assign rise    = pwm_s & ~pwm_d;
    assign tmo_hit = (per_cnt == TMO) && !rise;
    assign cap     = rise && armed;
    assign drop    = cap && (state != IDLE);
    assign last_it = (it_q == IT_LAST);

    // Counters restart at 1 on a rise so the rise cycle itself is counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
            armed   <= 1'b0;
        end else if (rise) begin
            per_cnt <= CNT_W'(1);
            hi_cnt  <= CNT_W'(1);
            armed   <= 1'b1;
        end else begin
            if (tmo_hit) begin
                per_cnt <= CNT_W'(1);
                armed   <= 1'b0;
            end else if (per_cnt != CNT_MAX) begin
                per_cnt <= per_cnt + CNT_W'(1);
            end
            if (pwm_s && (hi_cnt != CNT_MAX)) begin
                hi_cnt <= hi_cnt + CNT_W'(1);
            end
        end
    end

    // A timeout seen while dividing is held until the FSM is idle again,
    // so its update never lands on the same cycle as a division result.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_pend <= 1'b0;
            tmo_lvl  <= 1'b0;
        end else if (tmo_apply) begin
            tmo_pend <= 1'b0;
        end else if (tmo_hit) begin
            tmo_pend <= 1'b1;
            tmo_lvl  <= pwm_s;
        end
    end

    assign tmo_val = tmo_pend ? tmo_lvl : pwm_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (cap) state_nx = DIV;
            DIV:     if (last_it) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        div_load  = 1'b0;
        div_step  = 1'b0;
        div_fin   = 1'b0;
        tmo_apply = 1'b0;
        unique case (state)
            IDLE: begin
                div_load  = cap;
                tmo_apply = tmo_hit || tmo_pend;
            end
            DIV: begin
                div_step = 1'b1;
                div_fin  = last_it;
            end
            default: ;
        endcase
    end

    // Restoring divider: the shifted divisor starts at P<<W and walks
    // down one bit per cycle, giving W+1 quotient bits MSB first.
    assign ge     = (rem_q >= dsh_q);
    assign rem_nx = ge ? (rem_q - dsh_q) : rem_q;
    assign q_nx   = {q_q[W-1:0], ge};
    assign q_sat  = q_nx[W] ? '1 : q_nx[W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            dsh_q <= '0;
            q_q   <= '0;
            it_q  <= '0;
            p_q   <= '0;
            h_q   <= '0;
        end else if (div_load) begin
            rem_q <= {hi_cnt, {W{1'b0}}};
            dsh_q <= {per_cnt, {W{1'b0}}};
            q_q   <= '0;
            it_q  <= '0;
            p_q   <= per_cnt;
            h_q   <= hi_cnt;
        end else if (div_step) begin
            rem_q <= rem_nx;
            dsh_q <= dsh_q >> 1;
            q_q   <= q_nx;
            it_q  <= it_q + IT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty         <= '0;
            duty_valid   <= 1'b0;
            period       <= '0;
            high_time    <= '0;
            static_level <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            if (div_fin) begin
                duty         <= q_sat;
                period       <= p_q;
                high_time    <= h_q;
                static_level <= 1'b0;
                duty_valid   <= 1'b1;
            end else if (tmo_apply) begin
                duty         <= tmo_val ? '1 : '0;
                period       <= '0;
                high_time    <= '0;
                static_level <= 1'b1;
                duty_valid   <= 1'b1;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Scoreboard bench for pwm_duty_decoder: a cycle-indexed reference model
// predicts every update; a monitor pops and compares on duty_valid.
module tb_pwm_duty_decoder;

    localparam int W       = 4;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1024;
    localparam int NCYC    = 16384;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pwm_in = 1'b0;
    logic [W-1:0]     duty;
    logic             duty_valid;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             static_level;
    logic             overrun;

    pwm_duty_decoder #(
        .W(W),
        .CNT_W(CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pwm_in(pwm_in),
        .duty(duty),
        .duty_valid(duty_valid),
        .period(period),
        .high_time(high_time),
        .static_level(static_level),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int duty;
        int per;
        int hi;
        bit st;
        int at;
    } exp_t;

    exp_t sbq[$];
    int   errs = 0;
    int   checks = 0;

    bit drv[NCYC];
    bit sh[NCYC];
    bit rst_prev = 1'b1;
    int t0 = 0;
    bit armed = 1'b0;
    bit prev_s = 1'b0;
    int last_rise = 0;
    int last_restart = 0;
    int busy_done = -100;
    bit exp_ovr = 1'b0;
    int last_meas = -1000;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference model, evaluated once per cycle t on the synchronized
    // view of the input (the driven value two cycles earlier).
    task automatic model(input int t);
        bit s;
        bit r;
        int p;
        int h;
        int d;
        if (rst_prev) begin
            t0 = t;
            armed = 1'b0;
            prev_s = 1'b0;
            last_restart = t;
            busy_done = -100;
            exp_ovr = 1'b0;
            for (int i = sbq.size() - 1; i >= 0; i--)
                if (sbq[i].at >= t) sbq.delete(i);
            sh[t] = 1'b0;
            return;
        end
        s = (t - 2 >= t0) ? drv[t-2] : 1'b0;
        sh[t] = s;
        r = s && !prev_s;
        prev_s = s;
        if (r) begin
            if (armed) begin
                p = t - last_rise;
                h = 0;
                for (int k = last_rise; k < t; k++) h += int'(sh[k]);
                if (t > busy_done) begin
                    d = (h << W) / p;
                    if (d > (1 << W) - 1) d = (1 << W) - 1;
                    sbq.push_back('{duty: d, per: p, hi: h, st: 1'b0,
                                    at: t + W + 2});
                    busy_done = t + W + 2;
                end else begin
                    exp_ovr = 1'b1;
                end
            end
            armed = 1'b1;
            last_rise = t;
            last_restart = t;
        end else if (t - last_restart == TIMEOUT) begin
            last_restart = t;
            armed = 1'b0;
            sbq.push_back('{duty: s ? (1 << W) - 1 : 0, per: 0, hi: 0,
                            st: 1'b1,
                            at: (t <= busy_done) ? busy_done + 2 : t + 1});
        end
    endtask

    task automatic step(input bit v, input bit r);
        @(posedge clk);
        #1;
        pwm_in = v;
        rst = r;
        drv[cyc] = v;
        model(cyc);
        rst_prev = r;
    endtask

    task automatic chk_zero();
        chk("rst_duty", longint'(duty), 0);
        chk("rst_valid", longint'(duty_valid), 0);
        chk("rst_period", longint'(period), 0);
        chk("rst_high", longint'(high_time), 0);
        chk("rst_static", longint'(static_level), 0);
        chk("rst_overrun", longint'(overrun), 0);
    endtask

    task automatic frames(input int per, input int hi, input int n,
                          input int rf, input int ro);
        for (int f = 0; f < n; f++) begin
            for (int k = 0; k < per; k++) begin
                step(k < hi, (f == rf) && (k == ro));
                if ((f == rf) && (k == ro + 1)) chk_zero();
            end
        end
    endtask

    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) step(v, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (duty_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_valid: got pulse at %0d, none required",
                         cyc);
            end else begin
                e = sbq.pop_front();
                chk("valid_cycle", longint'(cyc), longint'(e.at));
                chk("duty", longint'(duty), longint'(e.duty));
                chk("period", longint'(period), longint'(e.per));
                chk("high_time", longint'(high_time), longint'(e.hi));
                chk("static_level", longint'(static_level), longint'(e.st));
            end
            if (!static_level) begin
                chk("pulse_gap_ok", longint'(cyc - last_meas >= W + 2), 1);
                last_meas = cyc;
            end
        end
    end

    initial begin
        int p;
        int h;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk_zero();

        frames(16, 5, 6, -1, 0);
        frames(16, 12, 4, -1, 0);
        frames(100, 33, 4, -1, 0);
        for (int i = 0; i < 20; i++) begin
            p = int'($urandom_range(12, 60));
            h = int'($urandom_range(1, p - 1));
            frames(p, h, 1, -1, 0);
        end
        hold(1'b0, 20);
        chk("overrun_clean", longint'(overrun), longint'(exp_ovr));

        frames(3, 1, 30, -1, 0);
        hold(1'b0, 20);
        chk("overrun_set", longint'(overrun), longint'(exp_ovr));
        chk("overrun_sticky", longint'(overrun), 1);

        frames(16, 5, 6, 2, 4);
        hold(1'b0, 20);
        chk("overrun_after_rst", longint'(overrun), longint'(exp_ovr));

        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        hold(1'b0, 2100);
        hold(1'b1, 2100);
        hold(1'b0, 30);

        chk("queue_drained", longint'(sbq.size()), 0);
        chk("overrun_final", longint'(overrun), longint'(exp_ovr));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
